// File: rtl/mpmc_pkg.sv
// Shared types for the two-port memory controller slice: default widths,
// requester FSM states and the buffered command record.
package mpmc_pkg;

    localparam int MPMC_ADDR_W = 4;
    localparam int MPMC_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        RESP = 2'd3
    } mpr_state_e;

    typedef struct packed {
        logic                   rw;
        logic [MPMC_ADDR_W-1:0] addr;
        logic [MPMC_DATA_W-1:0] wdata;
    } mpr_cmd_t;

endpackage

// File: rtl/mpr_cmd_fifo.sv
// Small command FIFO for the port requester; the head entry is visible
// combinationally so IDLE can latch it in the same cycle it pops.
module mpr_cmd_fifo
    import mpmc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  mpr_cmd_t wr_cmd,
    input  logic     pop,
    output mpr_cmd_t rd_cmd,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mpr_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_cmd  = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_cmd;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_requester.sv
// Processor-side initiator for one controller port: queues commands, runs the
// req/grant/hold handshake and returns responses. MPR_STATS_EN adds counters.
module mem_port_requester
    import mpmc_pkg::*;
#(
    parameter int ADDR_W        = MPMC_ADDR_W,
    parameter int DATA_W        = MPMC_DATA_W,
    parameter int CMD_DEPTH     = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int HOLD_CYCLES   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_rw,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              req,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic              grant,
    input  logic [DATA_W-1:0] data_out,
    output logic [15:0]       stat_done_cnt,
    output logic [15:0]       stat_timeout_cnt
);

    localparam int WAIT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    mpr_state_e        state_reg, state_next;
    mpr_cmd_t          op_reg, op_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    mpr_cmd_t          fifo_wr_cmd;
    mpr_cmd_t          fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign cmd_ready   = !fifo_full;
    assign fifo_wr_cmd = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

    mpr_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (cmd_valid),
        .wr_cmd (fifo_wr_cmd),
        .pop    (fifo_pop),
        .rd_cmd (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
            wait_cnt_reg <= wait_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        wait_cnt_next = wait_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        fifo_pop      = 1'b0;
        req           = 1'b0;
        rw            = 1'b0;
        addr          = '0;
        data_in       = '0;
        rsp_valid     = 1'b0;
        rsp_rw        = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    op_next       = fifo_head;
                    wait_cnt_next = '0;
                    err_next      = 1'b0;
                    rdata_next    = '0;
                    state_next    = REQ;
                end
            end
            REQ: begin
                req     = 1'b1;
                rw      = op_reg.rw;
                addr    = op_reg.addr;
                data_in = op_reg.wdata;
                // A grant in the final wait cycle still completes normally.
                if (grant) begin
                    rdata_next    = op_reg.rw ? '0 : data_out;
                    hold_cnt_next = '0;
                    state_next    = HOLD;
                end else if (wait_cnt_reg == WAIT_W'(GRANT_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    rdata_next = '0;
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                // Operands stay put while the controller finishes; it commits writes from them.
                rw      = op_reg.rw;
                addr    = op_reg.addr;
                data_in = op_reg.wdata;
                if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_next = RESP;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rw    = op_reg.rw;
                rsp_rdata = rdata_reg;
                rsp_err   = err_reg;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MPR_STATS_EN
    logic [15:0] done_cnt_reg;
    logic [15:0] timeout_cnt_reg;
    logic        rsp_fire;

    assign rsp_fire = (state_reg == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
        end else if (rsp_fire) begin
            if (err_reg) begin
                if (timeout_cnt_reg != 16'hFFFF) begin
                    timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                end
            end else if (done_cnt_reg != 16'hFFFF) begin
                done_cnt_reg <= done_cnt_reg + 1'b1;
            end
        end
    end

    assign stat_done_cnt    = done_cnt_reg;
    assign stat_timeout_cnt = timeout_cnt_reg;
`else
    assign stat_done_cnt    = '0;
    assign stat_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_requester.sv
// Bench for mem_port_requester: a simple controller model answers req/grant and
// an in-order response model predicts every completion.
module tb_mem_port_requester;

    localparam int ADDR_W        = 4;
    localparam int DATA_W        = 8;
    localparam int CMD_DEPTH     = 4;
    localparam int GRANT_TIMEOUT = 16;
    localparam int HOLD_CYCLES   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rw = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_rw;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              grant;
    logic [DATA_W-1:0] data_out;
    logic [15:0]       stat_done_cnt;
    logic [15:0]       stat_timeout_cnt;

    always #5 clk = ~clk;

    mem_port_requester #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .CMD_DEPTH     (CMD_DEPTH),
        .GRANT_TIMEOUT (GRANT_TIMEOUT),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rw           (cmd_rw),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rw           (rsp_rw),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .req              (req),
        .rw               (rw),
        .addr             (addr),
        .data_in          (data_in),
        .grant            (grant),
        .data_out         (data_out),
        .stat_done_cnt    (stat_done_cnt),
        .stat_timeout_cnt (stat_timeout_cnt)
    );

    // Controller model: grants after a chosen delay, commits writes at the end of the hold window.
    logic [DATA_W-1:0] init_mem [16];
    logic [DATA_W-1:0] ctrl_mem [16];
    bit                mem_loaded = 1'b0;
    int                delay_lo = 0;
    int                delay_hi = 0;
    bit                never_grant = 1'b0;
    int                req_age = 0;
    int                cur_delay = 0;
    int                hold_left = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic              hold_wr = 1'b0;

    assign grant    = req && !never_grant && (req_age == cur_delay);
    assign data_out = grant ? ctrl_mem[addr] : 8'hC3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_age   <= 0;
            cur_delay <= delay_lo;
            hold_left <= 0;
            if (!mem_loaded) begin
                for (int i = 0; i < 16; i++) ctrl_mem[i] <= init_mem[i];
                mem_loaded <= 1'b1;
            end
        end else begin
            if (!req || grant) begin
                req_age   <= 0;
                cur_delay <= $urandom_range(delay_hi, delay_lo);
            end else begin
                req_age <= req_age + 1;
            end
            if (grant) begin
                hold_left <= HOLD_CYCLES;
                hold_wr   <= rw;
                hold_addr <= addr;
            end else if (hold_left > 0) begin
                hold_left <= hold_left - 1;
                if (hold_left == 1 && hold_wr) ctrl_mem[hold_addr] <= data_in;
            end
        end
    end

    // Reference model: commands complete strictly in order against a flat memory.
    typedef struct {
        logic              rw;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    logic [DATA_W-1:0] ref_mem [16];
    rsp_t              exp_q [$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                n_rsp = 0;

    function automatic rsp_t ref_apply(input logic r, input logic [ADDR_W-1:0] a,
                                       input logic [DATA_W-1:0] d, input bit timeout);
        rsp_t e;
        e.rw = r;
        e.err = timeout;
        e.rdata = '0;
        if (!timeout) begin
            if (r) ref_mem[a] = d;
            else   e.rdata = ref_mem[a];
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the command is accepted.
    task automatic push(input logic r, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit timeout);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("push accepted", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_q.push_back(ref_apply(r, a, d, timeout));
    endtask

    task automatic collect(input string tag);
        int t = 0;
        rsp_t e;
        while (!rsp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        e = exp_q.pop_front();
        chk({tag, " rsp_rw"}, {31'd0, rsp_rw}, {31'd0, e.rw});
        chk({tag, " rsp_rdata"}, {24'd0, rsp_rdata}, {24'd0, e.rdata});
        chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        $display("rsp %0d [%s]: rw=%0d rdata=%02h err=%0d", n_rsp, tag, rsp_rw, rsp_rdata, rsp_err);
        n_rsp++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Waits for the grant, then checks addr holds for exactly HOLD_CYCLES with req low.
    task automatic watch_hold(input logic [ADDR_W-1:0] a);
        int t = 0;
        while (grant !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("grant seen", {31'd0, grant}, 32'd1);
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            @(negedge clk);
            chk("hold addr", {28'd0, addr}, {28'd0, a});
            chk("hold req", {31'd0, req}, 32'd0);
            chk("hold no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        chk("hold length", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin : main
        int   n;
        bit   seen;
        rsp_t e;
        logic r;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        for (int i = 0; i < 16; i++) begin
            init_mem[i] = DATA_W'($urandom);
            ref_mem[i]  = init_mem[i];
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset req", {31'd0, req}, 32'd0);
        chk("reset addr", {28'd0, addr}, 32'd0);
        chk("reset data_in", {24'd0, data_in}, 32'd0);
        chk("reset rw", {31'd0, rw}, 32'd0);
        chk("reset rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("reset stats", {stat_done_cnt, stat_timeout_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back address 5
        delay_lo = 2;
        delay_hi = 2;
        push(1'b1, 4'd5, 8'hA5, 1'b0);
        watch_hold(4'd5);
        collect("write a5");
        push(1'b0, 4'd5, 8'h00, 1'b0);
        watch_hold(4'd5);
        chk("readback value", {24'd0, rsp_rdata}, 32'h0000_00A5);
        collect("read a5");

        // Grant timeout
        never_grant = 1'b1;
        push(1'b0, 4'd3, 8'h00, 1'b1);
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout req cycles", n, GRANT_TIMEOUT);
        collect("timeout");
        never_grant = 1'b0;

        // Response backpressure with a second command queued behind
        delay_lo = 1;
        delay_hi = 1;
        push(1'b0, 4'd7, 8'h00, 1'b0);
        push(1'b1, 4'd9, 8'($urandom), 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            chk("bp rsp_rw", {31'd0, rsp_rw}, {31'd0, e.rw});
            chk("bp no req", {31'd0, req}, 32'd0);
            @(negedge clk);
        end
        collect("bp first");
        collect("bp second");

        // FIFO full: five back-to-back pushes with a slow grant
        delay_lo = 8;
        delay_hi = 8;
        for (int i = 0; i < 5; i++) begin
            r = 1'($urandom);
            a = 4'($urandom);
            d = 8'($urandom);
            push(r, a, d, 1'b0);
            if (i == 3) chk("cmd_ready before full", {31'd0, cmd_ready}, 32'd1);
        end
        chk("cmd_ready when full", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 5; i++) collect("fifo order");

        // Randomized batches
        delay_lo = 0;
        delay_hi = 6;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) begin
                r = 1'($urandom);
                a = 4'($urandom);
                d = 8'($urandom);
                push(r, a, d, 1'b0);
            end
            for (int i = 0; i < n; i++) collect("random");
        end

        // Reset while in HOLD, with a second command still in the FIFO
        delay_lo = 0;
        delay_hi = 0;
        push(1'b0, 4'd2, 8'h00, 1'b0);
        push(1'b0, 4'd4, 8'h00, 1'b0);
        n = 0;
        while (grant !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst req", {31'd0, req}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst addr", {28'd0, addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || req) seen = 1'b1;
        end
        chk("post-reset idle", {31'd0, seen}, 32'd0);

        // Statistics: three completions and one timeout
        delay_lo = 0;
        delay_hi = 4;
        for (int i = 0; i < 3; i++) begin
            r = 1'($urandom);
            a = 4'($urandom);
            d = 8'($urandom);
            push(r, a, d, 1'b0);
            collect("stats ok");
        end
        never_grant = 1'b1;
        push(1'b1, 4'd1, 8'h11, 1'b1);
        collect("stats timeout");
        never_grant = 1'b0;
        @(negedge clk);
`ifdef MPR_STATS_EN
        chk("stat_done_cnt", {16'd0, stat_done_cnt}, 32'd3);
        chk("stat_timeout_cnt", {16'd0, stat_timeout_cnt}, 32'd1);
`else
        chk("stat_done_cnt", {16'd0, stat_done_cnt}, 32'd0);
        chk("stat_timeout_cnt", {16'd0, stat_timeout_cnt}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_requester.md
Name: mem_port_requester

Overview:
- Processor-side initiator for one port of the two-port memory controller.
- Accepts read/write commands on a valid/ready command interface and buffers them in a small FIFO.
- Drives the controller's req/rw/addr/data_in and waits for grant, holding operands stable through the controller's processing window.
- Returns read data, or a completion or timeout error, on a valid/ready response interface.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, data width.
- CMD_DEPTH, 4, command FIFO depth (power of 2, ≥2).
- GRANT_TIMEOUT, 16, maximum cycles req stays asserted without grant before the command is abandoned.
- HOLD_CYCLES, 3, cycles operands are held after grant (controller processing window).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_rw  in  1  0=read, 1=write.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rw  out  1  rw of the completed command.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  grant timeout.
- req  out  1  to controller req_x.
- rw  out  1  to controller rw_x.
- addr  out  ADDR_W  to controller addr_x.
- data_in  out  DATA_W  to controller data_in_x.
- grant  in  1  from controller grant_x; combinational, one cycle.
- data_out  in  DATA_W  from controller data_out_x; valid only in the grant cycle.
- stat_done_cnt  out  16  completed commands (see Optional Feature).
- stat_timeout_cnt  out  16  timed-out commands (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs are 0, except cmd_ready=1.
  - FSM is in IDLE.
  - FIFO is empty.
  - Counters are 0.
- Reset mid-operation: req drops asynchronously, the FIFO is flushed, and any pending response is discarded.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - Pop only in IDLE.
  - A push and a pop in the same cycle are both honoured.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states are IDLE, REQ, HOLD and RESP.
- IDLE:
  - If the FIFO is not empty: pop, latch rw/addr/wdata into the operand registers, clear the wait counter, and go to REQ.
  - The first command reaches REQ one cycle after the push is accepted.
- REQ:
  - req=1; rw/addr/data_in are driven from the operand registers.
  - Each cycle without grant, the wait counter increments.
  - If grant=1 at a clock edge: capture data_out into the rdata register for a read (0 for a write), clear the hold counter, and go to HOLD.
  - If the wait counter reaches GRANT_TIMEOUT-1 without grant: set err=1, rdata=0, and go to RESP.
  - Grant and timeout in the same cycle: grant wins.
- HOLD:
  - req=0; rw/addr/data_in stay stable, so the controller commits writes from these inputs at the end of processing.
  - After HOLD_CYCLES cycles, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rw/rsp_rdata/rsp_err are stable until rsp_ready.
  - On the handshake, go to IDLE; the next command may be popped in the following cycle.
- Outside REQ: req=0, and grant is ignored.
- Outside REQ and HOLD: addr/data_in/rw are driven to 0.
- Counter widths:
  - Wait counter: $clog2(GRANT_TIMEOUT+1).
  - Hold counter: $clog2(HOLD_CYCLES+1).
  - All increments are unsigned with no wrap within range.
- Controller LOW_POWER needs no special handling: req wakes the controller, and grant arrives later within the timeout budget.

Optional Feature:
- Macro MPR_STATS_EN.
- When defined:
  - stat_done_cnt increments on each non-error response handshake.
  - stat_timeout_cnt increments on each error response handshake.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, both outputs are tied to 0 and no counter logic is generated.

Decomposition:
- Package mpmc_pkg holds:
  - ADDR_W/DATA_W defaults.
  - The requester state enum (IDLE, REQ, HOLD, RESP).
  - A command struct {rw, addr, wdata}.
- One sub-module, mpr_cmd_fifo: a parameterised synchronous FIFO of command structs, with full/empty outputs and the same clk/rst_n.

Test Plan:
- Write then read: push write addr=5 wdata=8'hA5, then read addr=5, against the controller model.
  - The write response has rsp_err=0.
  - The read response has rsp_rdata=8'hA5.
  - addr stays stable at 5 for HOLD_CYCLES after each grant.
- Timeout: grant tied 0, GRANT_TIMEOUT=16.
  - req is high for exactly 16 cycles, then drops.
  - rsp_err=1 and rsp_rdata=0.
- Backpressure: rsp_ready held 0 for 10 cycles.
  - rsp_valid and the response fields are stable.
  - No new req is issued until the handshake.
- FIFO full: push 5 commands back-to-back with CMD_DEPTH=4 while grant is delayed.
  - cmd_ready drops after 4 unpopped entries.
  - All commands complete in order.
- Reset in HOLD: assert rst_n=0 mid-HOLD.
  - req/rsp_valid are immediately 0 and cmd_ready=1.
  - After release, the FIFO is empty and no response appears.
- With MPR_STATS_EN: 3 successful commands plus 1 timeout give stat_done_cnt=3 and stat_timeout_cnt=1.
